// File: rtl/clct_cclut_fit_pipe_pkg.sv
// clct_cclut_fit_pipe_pkg: pattern and ccLUT field widths shared by the fit pipeline
package clct_cclut_fit_pipe_pkg;
    localparam int MXPATB  = 7;
    localparam int MXKEYBX = 8;
    localparam int MXPATC  = 12;
    localparam int MXOFFSB = 4;
    localparam int MXSLPB  = 4;
    localparam int MXXKYB  = 10;
    localparam int NHS     = 224;
    localparam int NPID    = 5;
    localparam int MXLUTA  = 3 + MXPATC;
    localparam int MXLUTD  = MXOFFSB + MXSLPB;
    localparam logic [3:0] NPID4 = 4'(NPID);
    localparam logic signed [MXXKYB:0] XS_MAX = (MXXKYB + 1)'(4 * NHS - 1);
endpackage

// File: rtl/clct_cclut_fit_pipe_cclut_rom.sv
// clct_cclut_fit_pipe_cclut_rom: read-first dual-port ccLUT, one write port and one registered read port
//   clock  : clock
//   radr   : read address, data in rdata one clock later (old data on write collision)
//   we/wadr/wdata : write port, usable on any clock
module clct_cclut_fit_pipe_cclut_rom #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata
);
    logic [DW-1:0] mem [0:(1 << AW) - 1];
    always_ff @(posedge clock) begin
        rdata <= mem[radr];
        if (we) mem[wadr] <= wdata;
    end
endmodule

// File: rtl/clct_cclut_fit_pipe.sv
// clct_cclut_fit_pipe: 3-clock ccLUT fit stage turning the sorter winner into a 1/8-strip key, bend and vpf
//   clock/reset   : clock, async active-high reset
//   in_valid, best_pat, best_key, best_carry, hit_thresh : sorter winner and layer threshold
//   lut_we, lut_wadr, lut_wdata : ccLUT load port {pid[2:0],cc} <= {offs,slope}
//   out_valid, out_vpf, out_pat, out_xky, out_bend : fit result, 3 clocks after input
//   pid_err_cnt   : saturating count of valid events carrying an out-of-range pid
module clct_cclut_fit_pipe
    import clct_cclut_fit_pipe_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [MXPATB-1:0]  best_pat,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic [MXPATC-1:0]  best_carry,
    input  logic [2:0]         hit_thresh,
    input  logic               lut_we,
    input  logic [MXLUTA-1:0]  lut_wadr,
    input  logic [MXLUTD-1:0]  lut_wdata,
    output logic               out_valid,
    output logic               out_vpf,
    output logic [MXPATB-1:0]  out_pat,
    output logic [MXXKYB-1:0]  out_xky,
    output logic [4:0]         out_bend,
    output logic [15:0]        pid_err_cnt
);
    logic               s0_v, s1_v;
    logic [MXPATB-1:0]  s0_pat, s1_pat;
    logic [MXKEYBX-1:0] s0_key, s1_key;
    logic [MXPATC-1:0]  s0_carry;
    logic [2:0]         s0_thr, s1_thr;
    logic [MXLUTD-1:0]  lut_rd;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_v     <= 1'b0;
            s0_pat   <= '0;
            s0_key   <= '0;
            s0_carry <= '0;
            s0_thr   <= '0;
            s1_v     <= 1'b0;
            s1_pat   <= '0;
            s1_key   <= '0;
            s1_thr   <= '0;
        end else begin
            s0_v     <= in_valid;
            s0_pat   <= best_pat;
            s0_key   <= best_key;
            s0_carry <= best_carry;
            s0_thr   <= hit_thresh;
            s1_v     <= s0_v;
            s1_pat   <= s0_pat;
            s1_key   <= s0_key;
            s1_thr   <= s0_thr;
        end
    end
    clct_cclut_fit_pipe_cclut_rom #(.AW(MXLUTA), .DW(MXLUTD)) u_rom (
        .clock (clock),
        .radr  ({s0_pat[2:0], s0_carry}),
        .rdata (lut_rd),
        .we    (lut_we),
        .wadr  (lut_wadr),
        .wdata (lut_wdata)
    );
    logic                     pid_ok;
    logic signed [MXOFFSB-1:0] offs;
    logic [MXSLPB-1:0]        slope;
    logic signed [MXXKYB:0]   xs;
    logic [MXXKYB-1:0]        xky;
    assign pid_ok = s1_pat[3:0] < NPID4;
    assign offs   = pid_ok ? lut_rd[MXLUTD-1:MXSLPB] : '0;
    assign slope  = pid_ok ? lut_rd[MXSLPB-1:0] : '0;
    // centre of the half-strip is 1/8-strip 2, hence the appended 2'b10
    assign xs     = $signed({1'b0, s1_key, 2'b10}) + offs;
    assign xky    = xs < 0 ? '0 : xs > XS_MAX ? XS_MAX[MXXKYB-1:0] : xs[MXXKYB-1:0];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_vpf     <= 1'b0;
            out_pat     <= '0;
            out_xky     <= '0;
            out_bend    <= '0;
            pid_err_cnt <= '0;
        end else begin
            out_valid <= s1_v;
            out_vpf   <= pid_ok && (s1_pat[6:4] >= s1_thr);
            out_pat   <= s1_pat;
            out_xky   <= xky;
            // an out-of-range pid has no defined bend, so the direction bit is dropped too
            out_bend  <= pid_ok ? {s1_pat[0], slope} : '0;
            if (s1_v && !pid_ok && pid_err_cnt != 16'hFFFF) pid_err_cnt <= pid_err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_clct_cclut_fit_pipe.sv
// tb_clct_cclut_fit_pipe: directed scoreboard bench for the ccLUT fit pipeline
module tb_clct_cclut_fit_pipe;
    typedef struct packed {
        logic       vpf;
        logic [6:0] pat;
        logic [9:0] xky;
        logic [4:0] bend;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [6:0]  best_pat = '0;
    logic [7:0]  best_key = '0;
    logic [11:0] best_carry = '0;
    logic [2:0]  hit_thresh = '0;
    logic        lut_we = 1'b0;
    logic [14:0] lut_wadr = '0;
    logic [7:0]  lut_wdata = '0;
    logic        out_valid, out_vpf;
    logic [6:0]  out_pat;
    logic [9:0]  out_xky;
    logic [4:0]  out_bend;
    logic [15:0] pid_err_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    logic [7:0] lut_m [int];

    clct_cclut_fit_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .best_pat(best_pat),
        .best_key(best_key), .best_carry(best_carry), .hit_thresh(hit_thresh),
        .lut_we(lut_we), .lut_wadr(lut_wadr), .lut_wdata(lut_wdata),
        .out_valid(out_valid), .out_vpf(out_vpf), .out_pat(out_pat), .out_xky(out_xky),
        .out_bend(out_bend), .pid_err_cnt(pid_err_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t model(input logic [6:0] pat, input logic [7:0] key,
                                   input logic [11:0] cc, input logic [2:0] thr);
        exp_t m;
        int a = int'({pat[2:0], cc});
        logic ok = pat[3:0] < 4'd5;
        logic [7:0] d = (ok && lut_m.exists(a)) ? lut_m[a] : 8'h00;
        int offs = int'($signed(d[7:4]));
        int xs = 4 * int'(key) + 2 + offs;
        m.vpf  = ok && (pat[6:4] >= thr);
        m.pat  = pat;
        m.xky  = xs < 0 ? 10'd0 : xs > 895 ? 10'd895 : 10'(xs);
        m.bend = ok ? {pat[0], d[3:0]} : 5'd0;
        return m;
    endfunction

    task automatic lut_wr(input logic [2:0] pid, input logic [11:0] cc, input logic [7:0] d);
        lut_we = 1'b1;
        lut_wadr = {pid, cc};
        lut_wdata = d;
        tick;
        lut_we = 1'b0;
        lut_m[int'({pid, cc})] = d;
    endtask

    task automatic drive(input logic [6:0] pat, input logic [7:0] key,
                         input logic [11:0] cc, input logic [2:0] thr, input exp_t e);
        in_valid = 1'b1;
        best_pat = pat;
        best_key = key;
        best_carry = cc;
        hit_thresh = thr;
        q.push_back(e);
        tick;
    endtask

    task automatic send(input logic [6:0] pat, input logic [7:0] key,
                        input logic [11:0] cc, input logic [2:0] thr);
        drive(pat, key, cc, thr, model(pat, key, cc, thr));
    endtask

    task automatic drain;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick;
        tick;
        chk("drain_left", q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else chk("evt", {out_vpf, out_pat, out_xky, out_bend}, q.pop_front());
        end
    end

    logic [6:0]  st_pat [8] = '{7'b111_0000, 7'b011_0001, 7'b100_0010, 7'b010_0011,
                               7'b110_0100, 7'b001_0000, 7'b111_0001, 7'b101_0100};
    logic [7:0]  st_key [8] = '{8'd1, 8'd17, 8'd60, 8'd99, 8'd128, 8'd200, 8'd222, 8'd7};
    logic [2:0]  st_thr [8] = '{3'd3, 3'd4, 3'd2, 3'd2, 3'd7, 3'd0, 3'd6, 3'd5};

    initial begin
        int n;
        repeat (3) tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_vpf", out_vpf, 0);
        chk("rst_pat", out_pat, 0);
        chk("rst_xky", out_xky, 0);
        chk("rst_bend", out_bend, 0);
        chk("rst_cnt", pid_err_cnt, 0);
        reset = 1'b0;
        tick;

        lut_wr(3'd2, 12'h0A5, 8'hF3);
        lut_wr(3'd4, 12'h0A5, 8'hF3);
        lut_wr(3'd1, 12'h011, 8'h85);
        lut_wr(3'd3, 12'h7FF, 8'h7A);
        drive(7'b110_0100, 8'd100, 12'h0A5, 3'd4, '{1'b1, 7'b110_0100, 10'd401, 5'b0_0011});
        drive(7'b011_0001, 8'd0, 12'h011, 3'd3, '{1'b1, 7'b011_0001, 10'd0, 5'b1_0101});
        drive(7'b101_0011, 8'd223, 12'h7FF, 3'd6, '{1'b0, 7'b101_0011, 10'd895, 5'b1_1010});
        drain;

        for (int i = 0; i < 8; i++) lut_wr(st_pat[i][2:0], 12'h100 + 12'(i * 37), 8'(8'h5C + i * 29));
        for (int i = 0; i < 8; i++) send(st_pat[i], st_key[i], 12'h100 + 12'(i * 37), st_thr[i]);
        drain;

        lut_wr(3'd0, 12'h123, 8'h12);
        send(7'b111_0000, 8'd50, 12'h123, 3'd1);
        in_valid = 1'b0;
        lut_we = 1'b1;
        lut_wadr = {3'd0, 12'h123};
        lut_wdata = 8'h34;
        tick;
        lut_we = 1'b0;
        lut_m[int'({3'd0, 12'h123})] = 8'h34;
        send(7'b111_0000, 8'd50, 12'h123, 3'd1);
        drain;
        chk("cnt_zero", pid_err_cnt, 0);

        for (int i = 0; i < 3; i++)
            drive(7'b111_0111, 8'd10, 12'h000, 3'd0, '{1'b0, 7'b111_0111, 10'd42, 5'd0});
        drain;
        chk("cnt_three", pid_err_cnt, 3);

        for (int i = 0; i < 5; i++) send(7'b111_0111, 8'(i), 12'h000, 3'd0);
        reset = 1'b1;
        q.delete();
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_vpf", out_vpf, 0);
        chk("mid_pat", out_pat, 0);
        chk("mid_xky", out_xky, 0);
        chk("mid_bend", out_bend, 0);
        chk("mid_cnt", pid_err_cnt, 0);
        tick;
        tick;
        in_valid = 1'b0;
        reset = 1'b0;
        tick;
        send(7'b011_0001, 8'd0, 12'h011, 3'd3);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick;
            n++;
        end
        chk("first_latency", n, 3);
        drain;

        for (int i = 0; i < 65540; i++) send(7'b111_0111, 8'(i), 12'h000, 3'd0);
        drain;
        chk("cnt_sat", pid_err_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
